// File: rtl/cmp_arbiter_pkg.sv
// Shared defaults and helpers for the comparator arbiter and its grant logic.
package cmp_arbiter_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 6;
   localparam int LAT_DEF   = 2;

   // Width of a requester index; never narrower than one bit.
   function automatic int idWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cmp_arbiter_rr.sv
// Round-robin grant selection: scans from the pointer, returns a one-hot grant
// plus the pointer value to load when that grant is taken.
module rr_arbiter
   import cmp_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]            req,
   input  logic [idWidth(N)-1:0]   ptr,
   input  logic                    hold,
   output logic [N-1:0]            gnt,
   output logic                    gntValid,
   output logic [idWidth(N)-1:0]   gntId,
   output logic [idWidth(N)-1:0]   nextPtr
);

   localparam int IDW = idWidth(N);

   // First requester at or after the pointer wins; hold suppresses all grants.
   always_comb begin
      int idx;
      gnt      = '0;
      gntValid = 1'b0;
      gntId    = '0;
      nextPtr  = ptr;
      idx      = 0;
      if (!hold) begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gntValid && req[idx]) begin
               gntValid = 1'b1;
               gnt[idx] = 1'b1;
               gntId    = IDW'(idx);
               nextPtr  = IDW'((idx + 1) % N);
            end
         end
      end
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one external, pipelined comparator among N_REQ requesters. Grants are
// round-robin, operands are registered toward the comparator, and a valid/id
// shift pipeline tags each result with its owner LAT+1 cycles after the grant.
module cmp_arbiter
   import cmp_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF,
   parameter int LAT   = LAT_DEF
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*W-1:0]          a_in,
   input  logic [N_REQ*W-1:0]          b_in,
   input  logic [N_REQ-1:0]            s_in,
   input  logic                        hold,
   output logic [N_REQ-1:0]            gnt,
   output logic [W-1:0]                cmp_a,
   output logic [W-1:0]                cmp_b,
   output logic                        cmp_s,
   input  logic                        cmp_e,
   input  logic                        cmp_l,
   input  logic                        cmp_g,
   output logic                        rsp_valid,
   output logic [idWidth(N_REQ)-1:0]   rsp_id,
   output logic                        rsp_e,
   output logic                        rsp_l,
   output logic                        rsp_g,
   output logic                        busy
);

   localparam int IDW = idWidth(N_REQ);

   logic            rstDone;
   logic            blockGnt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  nextPtr;
   logic [IDW-1:0]  gntId;
   logic            gntValid;
   logic [LAT:0]    vldPipe;
   logic [IDW-1:0]  idPipe [LAT+1];

   // No grants in the first cycle after reset release.
   assign blockGnt = hold | ~rstDone;

   rr_arbiter #(.N(N_REQ)) uArb (
      .req      (req),
      .ptr      (ptr),
      .hold     (blockGnt),
      .gnt      (gnt),
      .gntValid (gntValid),
      .gntId    (gntId),
      .nextPtr  (nextPtr)
   );

   // Marks that one full clock edge has passed since reset release.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) rstDone <= 1'b0;
      else      rstDone <= 1'b1;
   end

   // Round-robin pointer advances only on a grant.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)          ptr <= '0;
      else if (gntValid) ptr <= nextPtr;
   end

   // Granted requester's operands and mode are registered toward the comparator.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cmp_a <= '0;
         cmp_b <= '0;
         cmp_s <= 1'b0;
      end else if (gntValid) begin
         cmp_a <= a_in[int'(gntId)*W +: W];
         cmp_b <= b_in[int'(gntId)*W +: W];
         cmp_s <= s_in[gntId];
      end
   end

   // Valid/id shift line; stage LAT lines up with the comparator result.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vldPipe <= '0;
         for (int k = 0; k <= LAT; k++) idPipe[k] <= '0;
      end else begin
         vldPipe[0] <= gntValid;
         idPipe[0]  <= gntId;
         for (int k = 1; k <= LAT; k++) begin
            vldPipe[k] <= vldPipe[k-1];
            idPipe[k]  <= idPipe[k-1];
         end
      end
   end

   // Result flags and id are only visible alongside rsp_valid.
   always_comb begin
      rsp_valid = vldPipe[LAT];
      rsp_id    = rsp_valid ? idPipe[LAT] : '0;
      rsp_e     = cmp_e & rsp_valid;
      rsp_l     = cmp_l & rsp_valid;
      rsp_g     = cmp_g & rsp_valid;
      busy      = |vldPipe;
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: provides the external comparator, drives requesters
// and checks grants, operands, busy and responses against a reference model.
module tb_cmp_arbiter;
   import cmp_arbiter_pkg::*;

   localparam int N   = N_REQ_DEF;
   localparam int W   = W_DEF;
   localparam int LAT = LAT_DEF;
   localparam int IDW = idWidth(N);

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N*W-1:0]    a_in = '0;
   logic [N*W-1:0]    b_in = '0;
   logic [N-1:0]      s_in = '0;
   logic              hold = 1'b0;
   logic [N-1:0]      gnt;
   logic [W-1:0]      cmp_a, cmp_b;
   logic              cmp_s;
   logic              cmp_e, cmp_l, cmp_g;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_e, rsp_l, rsp_g;
   logic              busy;

   always #5 CLK = ~CLK;

   cmp_arbiter #(.N_REQ(N), .W(W), .LAT(LAT)) dut (
      .CLK(CLK), .RST(RST), .req(req), .a_in(a_in), .b_in(b_in), .s_in(s_in),
      .hold(hold), .gnt(gnt), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_s(cmp_s),
      .cmp_e(cmp_e), .cmp_l(cmp_l), .cmp_g(cmp_g), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_e(rsp_e), .rsp_l(rsp_l), .rsp_g(rsp_g), .busy(busy)
   );

   // Value compare returning {equal, less, greater}.
   function automatic logic [2:0] refCmp(logic [W-1:0] a, logic [W-1:0] b, logic s);
      int va, vb;
      va = int'(a);
      vb = int'(b);
      if (s && a[W-1]) va = va - (1 << W);
      if (s && b[W-1]) vb = vb - (1 << W);
      return {va == vb, va < vb, va > vb};
   endfunction

   // External comparator: LAT registered stages after its operand inputs.
   logic [2:0] cmpPipe [LAT];
   always @(posedge CLK) begin
      cmpPipe[0] <= refCmp(cmp_a, cmp_b, cmp_s);
      for (int k = 1; k < LAT; k++) cmpPipe[k] <= cmpPipe[k-1];
   end
   assign {cmp_e, cmp_l, cmp_g} = cmpPipe[LAT-1];

   typedef struct {
      int         id;
      int         due;
      logic [2:0] flags;
   } rsp_t;

   rsp_t          expQ [$];
   int            nChecks = 0;
   int            nErrors = 0;
   int            cyc = 0;
   int            mPtr = 0;
   bit            mReady = 1'b0;
   bit [N-1:0]    pend = '0;
   logic [W-1:0]  opA [N];
   logic [W-1:0]  opB [N];
   logic          opS [N];
   logic [W-1:0]  mCmpA = '0;
   logic [W-1:0]  mCmpB = '0;
   logic          mCmpS = 1'b0;
   bit            holdDrv = 1'b0;
   bit            rstDrv = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive after the edge, check and advance the model mid-cycle.
   task automatic stepCycle();
      int g;
      int idx;
      @(posedge CLK);
      cyc++;
      mReady = (RST == 1'b1);
      #1;
      RST = rstDrv;
      if (!rstDrv) begin
         expQ.delete();
         mPtr   = 0;
         mReady = 1'b0;
         mCmpA  = '0;
         mCmpB  = '0;
         mCmpS  = 1'b0;
      end
      hold = holdDrv;
      for (int i = 0; i < N; i++) begin
         req[i]          = pend[i];
         a_in[i*W +: W]  = opA[i];
         b_in[i*W +: W]  = opB[i];
         s_in[i]         = opS[i];
      end
      @(negedge CLK);
      g = -1;
      if (mReady && !holdDrv) begin
         for (int k = 0; k < N; k++) begin
            idx = (mPtr + k) % N;
            if (g < 0 && pend[idx]) g = idx;
         end
      end
      checkVal("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
      checkVal("busy", 32'(busy), 32'(expQ.size() != 0));
      checkVal("operands", 32'({cmp_a, cmp_b, cmp_s}), 32'({mCmpA, mCmpB, mCmpS}));
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
         checkVal("rsp", 32'({rsp_valid, rsp_id, rsp_e, rsp_l, rsp_g}),
                  32'({1'b1, IDW'(expQ[0].id), expQ[0].flags}));
         void'(expQ.pop_front());
      end else begin
         checkVal("rsp_idle", 32'({rsp_valid, rsp_id, rsp_e, rsp_l, rsp_g}), 32'd0);
      end
      if (g >= 0) begin
         expQ.push_back('{g, cyc + 1 + LAT, refCmp(opA[g], opB[g], opS[g])});
         mPtr    = (g + 1) % N;
         pend[g] = 1'b0;
         mCmpA   = opA[g];
         mCmpB   = opB[g];
         mCmpS   = opS[g];
      end
   endtask

   task automatic doReset();
      pend   = '0;
      rstDrv = 1'b0;
      stepCycle();
      rstDrv = 1'b1;
      stepCycle();
   endtask

   task automatic setReq(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      opA[id]  = a;
      opB[id]  = b;
      opS[id]  = s;
      pend[id] = 1'b1;
   endtask

   task automatic oneCmp(input string tag, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic s, input logic [2:0] expFlags);
      pend = '0;
      setReq(id, a, b, s);
      stepCycle();
      repeat (LAT + 1) stepCycle();
      checkVal(tag, 32'({rsp_valid, rsp_id, rsp_e, rsp_l, rsp_g}), 32'({1'b1, IDW'(id), expFlags}));
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         opA[i] = '0;
         opB[i] = '0;
         opS[i] = 1'b0;
      end
      #1 RST = 1'b0;

      // Reset state with every requester asking.
      for (int i = 0; i < N; i++) setReq(i, W'($urandom), W'($urandom), 1'($urandom));
      rstDrv = 1'b0;
      repeat (2) stepCycle();
      checkVal("rst_gnt", 32'(gnt), 32'd0);
      checkVal("rst_cmp_a", 32'(cmp_a), 32'd0);
      rstDrv = 1'b1;
      stepCycle();
      checkVal("rel_gnt", 32'(gnt), 32'd0);
      pend = '0;

      // Single unsigned equal compare.
      setReq(0, 6'd2, 6'd2, 1'b0);
      stepCycle();
      checkVal("t036_gnt", 32'(gnt), 32'b0001);
      repeat (LAT + 1) stepCycle();
      checkVal("t036_rsp", 32'({rsp_valid, rsp_id, rsp_e, rsp_l, rsp_g}), 32'({1'b1, IDW'(0), 3'b100}));

      // Back-to-back round robin from pointer 0.
      doReset();
      for (int i = 0; i < N; i++) setReq(i, W'($urandom), W'($urandom), 1'($urandom));
      for (int k = 0; k <= N; k++) begin
         stepCycle();
         checkVal("t037_gnt", 32'(gnt), 32'd1 << (k % N));
         pend[k % N] = 1'b1;
      end
      pend = '0;
      repeat (LAT + 2) stepCycle();

      // Signed versus unsigned interpretation.
      doReset();
      oneCmp("t038_s_gt", 1, 6'b111110, 6'b111100, 1'b1, 3'b001);
      oneCmp("t038_u_lt", 1, 6'b000001, 6'b111111, 1'b0, 3'b010);
      oneCmp("t038_s_gt2", 1, 6'b000001, 6'b111111, 1'b1, 3'b001);
      oneCmp("t038_u_gt", 1, 6'b111110, 6'b111100, 1'b0, 3'b001);
      oneCmp("t038_s_min", 2, 6'b100000, 6'b011111, 1'b1, 3'b010);

      // Hold for two cycles with requests pending.
      doReset();
      for (int i = 0; i < 3; i++) setReq(i, W'($urandom), W'($urandom), 1'($urandom));
      stepCycle();
      checkVal("t039_first", 32'(gnt), 32'b0001);
      setReq(0, W'($urandom), W'($urandom), 1'($urandom));
      holdDrv = 1'b1;
      repeat (2) begin
         stepCycle();
         checkVal("t039_hold", 32'(gnt), 32'd0);
      end
      holdDrv = 1'b0;
      stepCycle();
      checkVal("t039_r1", 32'(gnt), 32'b0010);
      stepCycle();
      checkVal("t039_r2", 32'(gnt), 32'b0100);
      stepCycle();
      checkVal("t039_r0", 32'(gnt), 32'b0001);
      repeat (LAT + 2) stepCycle();

      // Reset while two compares are in flight.
      doReset();
      setReq(2, W'($urandom), W'($urandom), 1'($urandom));
      setReq(3, W'($urandom), W'($urandom), 1'($urandom));
      repeat (2) stepCycle();
      rstDrv = 1'b0;
      stepCycle();
      rstDrv = 1'b1;
      setReq(0, W'($urandom), W'($urandom), 1'($urandom));
      setReq(1, W'($urandom), W'($urandom), 1'($urandom));
      stepCycle();
      checkVal("t040_busy", 32'(busy), 32'd0);
      checkVal("t040_rsp", 32'(rsp_valid), 32'd0);
      stepCycle();
      checkVal("t040_gnt", 32'(gnt), 32'b0001);
      pend = '0;
      repeat (LAT + 2) stepCycle();

      // Random traffic, including dropped requests and hold.
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 55)
               setReq(i, W'($urandom), W'($urandom), 1'($urandom));
            else if (pend[i] && $urandom_range(0, 99) < 3)
               pend[i] = 1'b0;
         end
         holdDrv = ($urandom_range(0, 99) < 10);
         stepCycle();
      end
      pend    = '0;
      holdDrv = 1'b0;
      repeat (LAT + 2) stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
